alu_issue: RTL and testbench

- Decode/issue pipeline stage directly upstream of the registered ALU; accepts one RV64I integer instruction per cycle.
- Supported classes: OP, OP-IMM, LUI and AUIPC.
- Reads the register file, generates immediates and drives the ALU operand/control inputs from registered state.
- Tracks the in-flight ALU result for forwarding, and produces writeback tags aligned with the ALU result.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/imm_gen.sv | 26 ++
 rtl/alu_issue.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/funct encodings and decode types for the ALU issue stage
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ADD     = 3'b000;
  localparam logic [2:0] SLL     = 3'b001;
  localparam logic [2:0] SLT     = 3'b010;
  localparam logic [2:0] SLTU    = 3'b011;
  localparam logic [2:0] XOR     = 3'b100;
  localparam logic [2:0] SRL_SRA = 3'b101;
  localparam logic [2:0] OR      = 3'b110;
  localparam logic [2:0] AND     = 3'b111;

  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_NONE = 7'b0000000;

  typedef enum logic {
    IMM_I,
    IMM_U
  } imm_type_t;

  // True for the opcodes this stage can hand to the ALU.
  function automatic logic is_supported(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
           (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended I/U immediate generator
module imm_gen
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm_val
);

  // Low instruction bits never carry immediate data for I/U forms.
  logic unused_low_bits;
  assign unused_low_bits = ^inst[11:0];

  // Select and sign-extend the immediate field for the decoded format.
  always_comb begin
    imm_val = '0;
    case (imm_type)
      IMM_I:   imm_val = {{(XLEN-12){inst[31]}}, inst[31:20]};
      IMM_U:   imm_val = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      default: imm_val = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV64I decode/issue stage feeding a registered ALU, with result forwarding
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_res,
  output logic            imm,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            out_valid,
  output logic [4:0]      out_rd,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            illegal
);

  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic            fwd1;
  logic            fwd2;

  logic            accept;
  logic            transfer;
  logic [6:0]      opcode;

  logic            dec_ok;
  logic            dec_imm;
  logic [2:0]      dec_f3;
  logic [6:0]      dec_f7;
  logic            use_rs1;
  logic            use_rs2;
  logic            op1_is_pc;
  imm_type_t       imm_type;
  logic [XLEN-1:0] imm_val;

  logic            src1_fwd;
  logic            src2_fwd;
  logic [XLEN-1:0] src1_val;
  logic [XLEN-1:0] src2_val;

  assign opcode   = inst[6:0];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign in_ready = ~stall;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid && ~stall;

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst    (inst),
    .imm_type(imm_type),
    .imm_val (imm_val)
  );

  // Classify the incoming word and derive ALU control fields.
  always_comb begin
    dec_ok    = 1'b0;
    dec_imm   = 1'b0;
    dec_f3    = inst[14:12];
    dec_f7    = inst[31:25];
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    op1_is_pc = 1'b0;
    imm_type  = IMM_I;
    case (opcode)
      OPC_OP: begin
        dec_ok  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // bit 25 belongs to the 6-bit shamt, so it must not leak into funct7
        dec_ok  = 1'b1;
        use_rs1 = 1'b1;
        dec_imm = 1'b1;
        dec_f7  = {inst[31:26], 1'b0};
      end
      OPC_LUI: begin
        dec_ok   = 1'b1;
        dec_imm  = 1'b1;
        imm_type = IMM_U;
        dec_f3   = ADD;
        dec_f7   = F7_NONE;
      end
      OPC_AUIPC: begin
        dec_ok    = 1'b1;
        dec_imm   = 1'b1;
        op1_is_pc = 1'b1;
        imm_type  = IMM_U;
        dec_f3    = ADD;
        dec_f7    = F7_NONE;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Operand 1 source: x0, in-flight producer, result on the wb bus, or regfile.
  always_comb begin
    src1_fwd = 1'b0;
    src1_val = '0;
    if (!use_rs1) begin
      src1_val = op1_is_pc ? pc : '0;
    end else if (rs1_addr == 5'd0) begin
      src1_val = '0;
    end else if (transfer && (out_rd == rs1_addr) && (out_rd != 5'd0)) begin
      src1_fwd = 1'b1;
    end else if (wb_valid && (wb_rd == rs1_addr) && (wb_rd != 5'd0)) begin
      src1_val = alu_res;
    end else begin
      src1_val = rs1_data;
    end
  end

  // Operand 2 source: immediate for non-register forms, otherwise as operand 1.
  always_comb begin
    src2_fwd = 1'b0;
    src2_val = '0;
    if (!use_rs2) begin
      src2_val = imm_val;
    end else if (rs2_addr == 5'd0) begin
      src2_val = '0;
    end else if (transfer && (out_rd == rs2_addr) && (out_rd != 5'd0)) begin
      src2_fwd = 1'b1;
    end else if (wb_valid && (wb_rd == rs2_addr) && (wb_rd != 5'd0)) begin
      src2_val = alu_res;
    end else begin
      src2_val = rs2_data;
    end
  end

  // Issue registers, forwarding flags, writeback tag and illegal pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      imm       <= 1'b0;
      funct3    <= '0;
      funct7    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      fwd1      <= 1'b0;
      fwd2      <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal  <= accept && !dec_ok;
      wb_valid <= transfer && (out_rd != 5'd0);
      wb_rd    <= out_rd;
      if (stall) begin
        // capture the producer's result now; the ALU will move on after release
        if (fwd1) begin
          op1_q <= alu_res;
          fwd1  <= 1'b0;
        end
        if (fwd2) begin
          op2_q <= alu_res;
          fwd2  <= 1'b0;
        end
      end else if (accept && dec_ok) begin
        out_valid <= 1'b1;
        out_rd    <= inst[11:7];
        imm       <= dec_imm;
        funct3    <= dec_f3;
        funct7    <= dec_f7;
        op1_q     <= src1_val;
        op2_q     <= src2_val;
        fwd1      <= src1_fwd;
        fwd2      <= src2_fwd;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign op1 = fwd1 ? alu_res : op1_q;
  assign op2 = fwd2 ? alu_res : op2_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with regfile and registered ALU
module tb_alu_issue;

  localparam int XLEN = 64;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            stall;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_res;
  logic            imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            out_valid;
  logic [4:0]      out_rd;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            illegal;

  always #5 CLK = ~CLK;

  alu_issue #(.XLEN(XLEN)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .pc       (pc),
    .stall    (stall),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .alu_res  (alu_res),
    .imm      (imm),
    .op1      (op1),
    .op2      (op2),
    .funct3   (funct3),
    .funct7   (funct7),
    .out_valid(out_valid),
    .out_rd   (out_rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .illegal  (illegal)
  );

  // Register file: x1 = 10, x2 = 20 after reset; written at the end of the wb cycle.
  logic [63:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'd0;
      rf[1] <= 64'd10;
      rf[2] <= 64'd20;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= alu_res;
    end
  end

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic im);
    case (f3)
      3'd0:    return (!im && f7[5]) ? a - b : a + b;
      3'd1:    return a << b[5:0];
      3'd2:    return {63'b0, ($signed(a) < $signed(b))};
      3'd3:    return {63'b0, (a < b)};
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 64'($signed(a) >>> b[5:0]) : (a >> b[5:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Registered ALU frozen by stall.
  always @(posedge CLK) begin
    if (!RST_N) alu_res <= 64'd0;
    else if (!stall) alu_res <= alu_f(op1, op2, funct3, funct7, imm);
  end

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic        im;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
  } iss_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
  } wb_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void exp_iss(input logic [63:0] o1, input logic [63:0] o2, input logic im,
                                  input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd);
    iss_t e;
    e.op1 = o1; e.op2 = o2; e.im = im; e.f3 = f3; e.f7 = f7; e.rd = rd;
    iss_q.push_back(e);
  endfunction

  function automatic void exp_wb(input logic [4:0] rd, input logic [63:0] val);
    wb_t e;
    e.rd = rd; e.val = val;
    wb_q.push_back(e);
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {im, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {im, rd, opc};
  endfunction

  // Monitor: compare issued operands on each transfer and every writeback.
  always @(negedge CLK) begin
    iss_t ei;
    wb_t  ew;
    if (RST_N === 1'b1) begin
      if (out_valid && !stall) begin
        if (iss_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL issue_unexpected: got rd %0d expected no issue", out_rd);
        end else begin
          ei = iss_q.pop_front();
          check("op1", op1, ei.op1);
          check("op2", op2, ei.op2);
          check("imm", 64'(imm), 64'(ei.im));
          check("funct3", 64'(funct3), 64'(ei.f3));
          check("funct7", 64'(funct7), 64'(ei.f7));
          check("out_rd", 64'(out_rd), 64'(ei.rd));
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_unexpected: got rd %0d expected no writeback", wb_rd);
        end else begin
          ew = wb_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(ew.rd));
          check("wb_val", alu_res, ew.val);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] i, input logic [63:0] p);
    in_valid = 1'b1;
    inst     = i;
    pc       = p;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b1;
    inst     = enc_i(12'd1, 5'd1, 3'b000, 5'd5, 7'b0010011);
    pc       = 64'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_op1", op1, 64'd0);
    check("rst_op2", op2, 64'd0);
    RST_N    = 1'b1;
    in_valid = 1'b0;

    // addi x5,x0,-3 ; srai x6,x5,1 (distance-1 forward)
    exp_iss(64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 3'd0, 7'h7E, 5'd5);
    exp_wb(5'd5, 64'hFFFF_FFFF_FFFF_FFFD);
    exp_iss(64'hFFFF_FFFF_FFFF_FFFD, 64'h401, 1'b1, 3'd5, 7'h20, 5'd6);
    exp_wb(5'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(enc_i(12'hFFD, 5'd0, 3'b000, 5'd5, 7'b0010011), 64'd0);
    issue(enc_i(12'h401, 5'd5, 3'b101, 5'd6, 7'b0010011), 64'd4);

    // add x7,x1,x2 ; add x11,x2,x2 ; sub x8,x7,x1 (distance-2 from wb bus)
    exp_iss(64'd10, 64'd20, 1'b0, 3'd0, 7'h00, 5'd7);
    exp_wb(5'd7, 64'd30);
    exp_iss(64'd20, 64'd20, 1'b0, 3'd0, 7'h00, 5'd11);
    exp_wb(5'd11, 64'd40);
    exp_iss(64'd30, 64'd10, 1'b0, 3'd0, 7'h20, 5'd8);
    exp_wb(5'd8, 64'd20);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd7), 64'd8);
    issue(enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd11), 64'd12);
    issue(enc_r(7'h20, 5'd1, 5'd7, 3'b000, 5'd8), 64'd16);
    repeat (3) @(posedge CLK);
    #1;

    // addi x9,x0,5 ; add x10,x9,x9 held by 3 stall cycles
    exp_iss(64'd0, 64'd5, 1'b1, 3'd0, 7'h00, 5'd9);
    exp_wb(5'd9, 64'd5);
    exp_iss(64'd5, 64'd5, 1'b0, 3'd0, 7'h00, 5'd10);
    exp_wb(5'd10, 64'd10);
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd9, 7'b0010011), 64'd20);
    issue(enc_r(7'h00, 5'd9, 5'd9, 3'b000, 5'd10), 64'd24);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("stall_op1", op1, 64'd5);
      check("stall_op2", op2, 64'd5);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      if (k > 0) check("stall_wb_valid", 64'(wb_valid), 64'd0);
      @(posedge CLK);
      #1;
    end
    stall = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // lui x3,0x80000 ; auipc x4,1 at pc 0x1000
    exp_iss(64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1, 3'd0, 7'h00, 5'd3);
    exp_wb(5'd3, 64'hFFFF_FFFF_8000_0000);
    exp_iss(64'h1000, 64'h1000, 1'b1, 3'd0, 7'h00, 5'd4);
    exp_wb(5'd4, 64'h2000);
    issue(enc_u(20'h80000, 5'd3, 7'b0110111), 64'h0FFC);
    issue(enc_u(20'h00001, 5'd4, 7'b0010111), 64'h1000);

    // ld x12,0(x1): unsupported, dropped with a one-cycle illegal pulse
    issue(enc_i(12'd0, 5'd1, 3'b011, 5'd12, 7'b0000011), 64'h1004);
    @(negedge CLK);
    check("illegal_pulse", 64'(illegal), 64'd1);
    check("illegal_out_valid", 64'(out_valid), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("illegal_clear", 64'(illegal), 64'd0);

    // addi x0,x1,7 ; add x13,x0,x0: no writeback and no forwarding for x0
    exp_iss(64'd10, 64'd7, 1'b1, 3'd0, 7'h00, 5'd0);
    exp_iss(64'd0, 64'd0, 1'b0, 3'd0, 7'h00, 5'd13);
    exp_wb(5'd13, 64'd0);
    issue(enc_i(12'd7, 5'd1, 3'b000, 5'd0, 7'b0010011), 64'h1008);
    issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd13), 64'h100C);
    @(negedge CLK);
    check("x0_no_wb", 64'(wb_valid), 64'd0);
    repeat (4) @(posedge CLK);
    #1;

    // reset while an instruction is held by stall discards it
    issue(enc_i(12'd1, 5'd0, 3'b000, 5'd14, 7'b0010011), 64'h1010);
    stall = 1'b1;
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    stall = 1'b0;
    @(negedge CLK);
    check("rst_stall_out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(negedge CLK);
    check("wb_valid_idle", 64'(wb_valid), 64'd0);
    check("iss_q_drained", 64'(iss_q.size()), 64'd0);
    check("wb_q_drained", 64'(wb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
